// File: rtl/maze_pkg.sv
// Shared maze geometry, agent start positions and scheduler types.
// Wall rectangles match the background maze layer exactly (inclusive bounds).
package maze_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CALC   = 3'd1,
        S_CHECK  = 3'd2,
        S_COMMIT = 3'd3,
        S_DONE   = 3'd4
    } sched_state_t;

    localparam int COORD_W    = 11;
    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;
    localparam int SPRITE_W   = 32;
    localparam int SPRITE_H   = 32;
    localparam int MAX_AGENTS = 8;

    typedef logic [COORD_W-1:0] coord_t;
    // One extra bit so a box's far edge never wraps
    typedef logic [COORD_W:0]   ext_t;

    typedef struct packed {
        coord_t x0;
        coord_t y0;
        coord_t x1;
        coord_t y1;
    } rect_t;

    localparam coord_t PLAY_X_MIN = 11'd6;
    localparam coord_t PLAY_X_MAX = 11'd1018;
    localparam coord_t PLAY_Y_MIN = 11'd6;
    localparam coord_t PLAY_Y_MAX = 11'd762;

    localparam int N_WALLS = 5;
    localparam rect_t WALL_RECTS [N_WALLS] = '{
        '{x0: 11'd461, y0: 11'd349, x1: 11'd464, y1: 11'd419},  // ghost house left
        '{x0: 11'd560, y0: 11'd349, x1: 11'd563, y1: 11'd419},  // ghost house right
        '{x0: 11'd461, y0: 11'd416, x1: 11'd563, y1: 11'd419},  // ghost house floor
        '{x0: 11'd100, y0: 11'd100, x1: 11'd199, y1: 11'd139},
        '{x0: 11'd800, y0: 11'd600, x1: 11'd899, y1: 11'd639}
    };

    localparam coord_t START_X [MAX_AGENTS] = '{
        11'd496, 11'd470, 11'd510, 11'd300, 11'd40, 11'd900, 11'd40, 11'd900
    };
    localparam coord_t START_Y [MAX_AGENTS] = '{
        11'd720, 11'd370, 11'd370, 11'd200, 11'd40, 11'd40, 11'd700, 11'd700
    };

    function automatic logic boxes_overlap(
        input ext_t ax0, input ext_t ay0, input ext_t ax1, input ext_t ay1,
        input ext_t bx0, input ext_t by0, input ext_t bx1, input ext_t by1
    );
        return (ax0 <= bx1) && (bx0 <= ax1) && (ay0 <= by1) && (by0 <= ay1);
    endfunction

endpackage

// File: rtl/move_scheduler_wall_check.sv
// Shared wall-collision checker: tests a sprite-sized query box against every
// wall rectangle and the playfield interior in parallel; hit is registered.
module wall_check
    import maze_pkg::*;
#(
    parameter int POS_W = 11
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [POS_W-1:0] qx,
    input  logic [POS_W-1:0] qy,
    output logic             hit
);

    ext_t qx0_s;
    ext_t qy0_s;
    ext_t qx1_s;
    ext_t qy1_s;
    logic hit_s;
    logic hit_r;

    // Anything leaving the interior counts as wall, as does any rectangle overlap
    always_comb begin
        qx0_s = ext_t'(qx);
        qy0_s = ext_t'(qy);
        qx1_s = qx0_s + ext_t'(SPRITE_W - 1);
        qy1_s = qy0_s + ext_t'(SPRITE_H - 1);
        hit_s = (qx0_s < ext_t'(PLAY_X_MIN)) || (qx1_s > ext_t'(PLAY_X_MAX)) ||
                (qy0_s < ext_t'(PLAY_Y_MIN)) || (qy1_s > ext_t'(PLAY_Y_MAX));
        for (int w = 0; w < N_WALLS; w++) begin
            hit_s = hit_s | boxes_overlap(qx0_s, qy0_s, qx1_s, qy1_s,
                                          ext_t'(WALL_RECTS[w].x0), ext_t'(WALL_RECTS[w].y0),
                                          ext_t'(WALL_RECTS[w].x1), ext_t'(WALL_RECTS[w].y1));
        end
    end

    // Single-cycle checker latency
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_r <= 1'b0;
        end else begin
            hit_r <= hit_s;
        end
    end

    assign hit = hit_r;

endmodule

// File: rtl/move_scheduler.sv
// Per-frame agent mover: on each vblnk rising edge, walks agents 0..N-1 through
// one shared wall checker (3 cycles per agent). Optional MOVE_SCHED_COLLIDE_EN adds 'catch'.
module move_scheduler
    import maze_pkg::*;
#(
    parameter int N_AGENTS = 4,
    parameter int STEP     = 1,
    parameter int POS_W    = 11
)(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               vblnk,
    input  dir_t [N_AGENTS-1:0]                dir_req,
    input  logic [N_AGENTS-1:0]                dir_vld,
    output logic [N_AGENTS-1:0][POS_W-1:0]     xpos,
    output logic [N_AGENTS-1:0][POS_W-1:0]     ypos,
    output logic [N_AGENTS-1:0]                blocked,
    output logic                               busy,
    output logic                               frame_done
`ifdef MOVE_SCHED_COLLIDE_EN
    ,
    output logic                               catch
`endif
);

    localparam int IDX_W = (N_AGENTS > 1) ? $clog2(N_AGENTS) : 1;
    localparam logic [POS_W-1:0] STEP_C = POS_W'(STEP);

    sched_state_t state_r;
    sched_state_t state_next_s;

    logic                              vblnk_d_r;
    logic [IDX_W-1:0]                  idx_r;
    logic [N_AGENTS-1:0][POS_W-1:0]    xpos_r;
    logic [N_AGENTS-1:0][POS_W-1:0]    ypos_r;
    logic [N_AGENTS-1:0]               blocked_r;
    logic                              busy_r;
    logic                              frame_done_r;
    logic [POS_W-1:0]                  cand_x_r;
    logic [POS_W-1:0]                  cand_y_r;
    logic                              under_r;
    logic                              vld_r;

    logic                              start_s;
    logic                              last_s;
    logic                              hit_s;
    logic [POS_W-1:0]                  cur_x_s;
    logic [POS_W-1:0]                  cur_y_s;
    logic [POS_W-1:0]                  cand_x_s;
    logic [POS_W-1:0]                  cand_y_s;
    logic                              under_s;

    assign start_s = vblnk & ~vblnk_d_r;
    assign last_s  = (idx_r == IDX_W'(N_AGENTS - 1));

    wall_check #(.POS_W(POS_W)) u_wall_check (
        .clk (clk),
        .rst (rst),
        .qx  (cand_x_r),
        .qy  (cand_y_r),
        .hit (hit_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; edges arriving outside IDLE are dropped
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_s) state_next_s = S_CALC;
                else         state_next_s = S_IDLE;
            end
            S_CALC:   state_next_s = S_CHECK;
            S_CHECK:  state_next_s = S_COMMIT;
            S_COMMIT: begin
                if (last_s) state_next_s = S_DONE;
                else        state_next_s = S_CALC;
            end
            S_DONE:   state_next_s = S_IDLE;
            default:  state_next_s = S_IDLE;
        endcase
    end

    // Candidate position for the current agent; flags a move off the low edge
    always_comb begin
        cur_x_s  = xpos_r[idx_r];
        cur_y_s  = ypos_r[idx_r];
        cand_x_s = cur_x_s;
        cand_y_s = cur_y_s;
        under_s  = 1'b0;
        case (dir_req[idx_r])
            UP: begin
                cand_y_s = cur_y_s - STEP_C;
                under_s  = (cur_y_s < STEP_C);
            end
            DOWN:  cand_y_s = cur_y_s + STEP_C;
            LEFT: begin
                cand_x_s = cur_x_s - STEP_C;
                under_s  = (cur_x_s < STEP_C);
            end
            RIGHT: cand_x_s = cur_x_s + STEP_C;
            default: begin
                cand_x_s = cur_x_s;
                cand_y_s = cur_y_s;
            end
        endcase
    end

    // Per-agent datapath: sample in CALC, resolve in COMMIT
    always_ff @(posedge clk) begin
        if (rst) begin
            vblnk_d_r    <= 1'b0;
            idx_r        <= '0;
            blocked_r    <= '0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            cand_x_r     <= '0;
            cand_y_r     <= '0;
            under_r      <= 1'b0;
            vld_r        <= 1'b0;
            for (int i = 0; i < N_AGENTS; i++) begin
                xpos_r[i] <= POS_W'(START_X[i]);
                ypos_r[i] <= POS_W'(START_Y[i]);
            end
        end else begin
            vblnk_d_r    <= vblnk;
            busy_r       <= (state_next_s == S_CALC) || (state_next_s == S_CHECK) ||
                            (state_next_s == S_COMMIT);
            frame_done_r <= (state_next_s == S_DONE);
            case (state_r)
                S_IDLE: idx_r <= '0;
                S_CALC: begin
                    cand_x_r <= cand_x_s;
                    cand_y_r <= cand_y_s;
                    under_r  <= under_s;
                    vld_r    <= dir_vld[idx_r];
                end
                S_COMMIT: begin
                    if (!vld_r) begin
                        blocked_r[idx_r] <= 1'b0;
                    end else if (hit_s || under_r) begin
                        blocked_r[idx_r] <= 1'b1;
                    end else begin
                        xpos_r[idx_r]    <= cand_x_r;
                        ypos_r[idx_r]    <= cand_y_r;
                        blocked_r[idx_r] <= 1'b0;
                    end
                    if (!last_s) idx_r <= idx_r + IDX_W'(1);
                    else         idx_r <= '0;
                end
                default: idx_r <= idx_r;
            endcase
        end
    end

    assign xpos       = xpos_r;
    assign ypos       = ypos_r;
    assign blocked    = blocked_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

`ifdef MOVE_SCHED_COLLIDE_EN
    logic overlap_s;
    logic catch_r;

    // Player box against every ghost box on committed positions
    always_comb begin
        overlap_s = 1'b0;
        for (int g = 1; g < N_AGENTS; g++) begin
            overlap_s = overlap_s | boxes_overlap(
                ext_t'(xpos_r[0]), ext_t'(ypos_r[0]),
                ext_t'(xpos_r[0]) + ext_t'(SPRITE_W - 1), ext_t'(ypos_r[0]) + ext_t'(SPRITE_H - 1),
                ext_t'(xpos_r[g]), ext_t'(ypos_r[g]),
                ext_t'(xpos_r[g]) + ext_t'(SPRITE_W - 1), ext_t'(ypos_r[g]) + ext_t'(SPRITE_H - 1));
        end
    end

    // Catch pulses the cycle after DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            catch_r <= 1'b0;
        end else begin
            catch_r <= (state_r == S_DONE) && overlap_s;
        end
    end

    assign catch = catch_r;
`endif

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler: a behavioural model predicts per-frame
// positions/blocked flags, queued at frame start and compared on frame_done.
module tb_move_scheduler;
    import maze_pkg::*;

    localparam int NA = 4;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         vblnk;
    dir_t [NA-1:0]                dir_req;
    logic [NA-1:0]                dir_vld;
    logic [NA-1:0][10:0]          xpos;
    logic [NA-1:0][10:0]          ypos;
    logic [NA-1:0]                blocked;
    logic                         busy;
    logic                         frame_done;
`ifdef MOVE_SCHED_COLLIDE_EN
    logic                         catch_s;
`endif

    move_scheduler #(.N_AGENTS(NA), .STEP(1), .POS_W(11)) dut (
        .clk        (clk),
        .rst        (rst),
        .vblnk      (vblnk),
        .dir_req    (dir_req),
        .dir_vld    (dir_vld),
        .xpos       (xpos),
        .ypos       (ypos),
        .blocked    (blocked),
        .busy       (busy),
`ifdef MOVE_SCHED_COLLIDE_EN
        .frame_done (frame_done),
        .catch      (catch_s)
`else
        .frame_done (frame_done)
`endif
    );

    always #5 clk = ~clk;

    // Independent copy of the maze geometry for the model
    localparam int WX0 [5] = '{461, 560, 461, 100, 800};
    localparam int WY0 [5] = '{349, 349, 416, 100, 600};
    localparam int WX1 [5] = '{464, 563, 563, 199, 899};
    localparam int WY1 [5] = '{419, 419, 419, 139, 639};
    localparam int SX  [4] = '{496, 470, 510, 300};
    localparam int SY  [4] = '{720, 370, 370, 200};

    typedef struct packed {
        logic [3:0][10:0] x;
        logic [3:0][10:0] y;
        logic [3:0]       b;
    } exp_t;

    exp_t sb_q[$];
    int   mx[4];
    int   my[4];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input int x, input int y);
        int x1 = x + 31;
        int y1 = y + 31;
        if (x < 6 || y < 6 || x1 > 1018 || y1 > 762) return 1'b1;
        for (int w = 0; w < 5; w++)
            if (x <= WX1[w] && x1 >= WX0[w] && y <= WY1[w] && y1 >= WY0[w]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mx[i] = SX[i];
            my[i] = SY[i];
        end
    endtask

    task automatic model_frame(input dir_t d [4], input logic [3:0] vld);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            e.b[i] = 1'b0;
            if (vld[i]) begin
                int cx = mx[i];
                int cy = my[i];
                case (d[i])
                    UP:      cy = cy - 1;
                    DOWN:    cy = cy + 1;
                    LEFT:    cx = cx - 1;
                    default: cx = cx + 1;
                endcase
                if (model_hit(cx, cy)) begin
                    e.b[i] = 1'b1;
                end else begin
                    mx[i] = cx;
                    my[i] = cy;
                end
            end
            e.x[i] = 11'(mx[i]);
            e.y[i] = 11'(my[i]);
        end
        sb_q.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        check_eq("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("xpos%0d", i), xpos[i], e.x[i]);
                check_eq($sformatf("ypos%0d", i), ypos[i], e.y[i]);
                check_eq($sformatf("blocked%0d", i), blocked[i], e.b[i]);
            end
        end
    endtask

    task automatic drive_req(input dir_t d [4], input logic [3:0] vld);
        for (int i = 0; i < 4; i++) dir_req[i] = d[i];
        dir_vld = vld;
        model_frame(d, vld);
    endtask

    // One full frame with latency and pulse-width checks
    task automatic run_frame(input dir_t d [4], input logic [3:0] vld);
        int n;
        drive_req(d, vld);
        vblnk = 1'b1;
        @(posedge clk); #1;
        check_eq("busy_start", busy, 1);
        n = 1;
        while (!frame_done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("latency", n, 13);
        check_eq("busy_in_done", busy, 0);
        compare_out();
        @(posedge clk); #1;
        check_eq("done_width", frame_done, 0);
        vblnk = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dir_t d [4];
        int pulses;

        rst     = 1'b1;
        vblnk   = 1'b0;
        dir_vld = 4'b0000;
        for (int i = 0; i < 4; i++) dir_req[i] = UP;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_xpos0", xpos[0], 496);
        check_eq("rst_ypos0", ypos[0], 720);
        check_eq("rst_xpos1", xpos[1], 470);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_blocked", blocked, 0);
        check_eq("rst_done", frame_done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Agent 0 moves right
        d = '{RIGHT, UP, UP, UP};
        run_frame(d, 4'b0001);

        // Agent 1 walks left into the ghost house wall
        d = '{UP, LEFT, UP, UP};
        repeat (6) run_frame(d, 4'b0010);

        // Agent 0 walks down to the playfield floor
        d = '{DOWN, UP, UP, UP};
        repeat (12) run_frame(d, 4'b0001);

        // All agents at once
        d = '{LEFT, RIGHT, UP, DOWN};
        run_frame(d, 4'b1111);

        // vblnk held high with an extra edge while busy: one frame only
        d = '{UP, UP, UP, UP};
        drive_req(d, 4'b1000);
        vblnk  = 1'b1;
        pulses = 0;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (c == 5) vblnk = 1'b0;
            if (c == 6) vblnk = 1'b1;
            if (frame_done) begin
                pulses++;
                if (pulses == 1) compare_out();
            end
        end
        check_eq("held_pulses", pulses, 1);
        check_eq("held_busy", busy, 0);
        check_eq("held_ypos3", ypos[3], my[3]);
        vblnk = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a frame
        d = '{RIGHT, RIGHT, RIGHT, RIGHT};
        for (int i = 0; i < 4; i++) dir_req[i] = d[i];
        dir_vld = 4'b1111;
        vblnk   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst   = 1'b1;
        vblnk = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_done", frame_done, 0);
        check_eq("mid_rst_blocked", blocked, 0);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("mid_rst_x%0d", i), xpos[i], mx[i]);
            check_eq($sformatf("mid_rst_y%0d", i), ypos[i], my[i]);
        end
        pulses = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (frame_done) pulses++;
        end
        check_eq("mid_rst_pulses", pulses, 0);

        // Recovery frame from start positions
        d = '{RIGHT, DOWN, LEFT, UP};
        run_frame(d, 4'b1111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
Once per video frame, this block updates the positions of all game agents: the player (agent 0) and the ghosts (agents 1..N_AGENTS-1).
- It starts at the rising edge of vertical blanking.
- Agents are served one at a time, in fixed order, through a single shared wall-collision checker.
- Each agent's move is committed only if the candidate sprite box does not overlap the maze walls drawn by the background layer.
- Outputs feed the sprite draw stages downstream of the background.

Parameters:
N_AGENTS, 4, number of agents scheduled per frame (1..8).
STEP, 1, pixels moved per accepted request.
POS_W, 11, width of position coordinates.

Ports:
clk  in  1  pixel clock.
rst  in  1  synchronous reset, active-high.
vblnk  in  1  vertical blanking from the VGA timing stream.
dir_req  in  N_AGENTS x 2  requested direction per agent (dir_t).
dir_vld  in  N_AGENTS  agent requests a move this frame.
xpos  out  N_AGENTS x POS_W  sprite top-left x per agent.
ypos  out  N_AGENTS x POS_W  sprite top-left y per agent.
blocked  out  N_AGENTS  last attempted move was rejected.
busy  out  1  scheduler is processing a frame.
frame_done  out  1  one-cycle pulse when all agents have been processed.

Behaviour:
- Reset values:
  - xpos/ypos = START_X[i]/START_Y[i]: agent0 (496,720), agent1 (470,370), agent2 (510,370), agent3 (300,200).
  - blocked, busy, frame_done = 0.
  - State = IDLE; internal vblnk_d = 0.
- Edge detect: start = vblnk & ~vblnk_d, evaluated only in IDLE. An edge seen while busy is ignored; no queuing.
- FSM states: IDLE, CALC, CHECK, COMMIT, DONE. Index i runs 0..N_AGENTS-1.
  - IDLE -> CALC on start. Set i=0, busy=1.
  - CALC:
    - Sample dir_req[i] and dir_vld[i].
    - Candidate = pos ± STEP on the selected axis (UP: y-STEP, DOWN: y+STEP, LEFT: x-STEP, RIGHT: x+STEP).
    - Register the candidate box (x, y, SPRITE_W, SPRITE_H) into the wall_check query.
    - If the subtraction would underflow, force the hit flag.
  - CHECK: the wall_check hit result is registered (1-cycle checker latency).
  - COMMIT:
    - If dir_vld[i]=0: position unchanged, blocked[i]=0.
    - Else if hit: position unchanged, blocked[i]=1.
    - Else: position = candidate, blocked[i]=0.
    - If i=N_AGENTS-1 go to DONE; otherwise i++ and go to CALC.
  - DONE: frame_done=1 for one cycle, busy=0, go to IDLE.
- Latency: frame_done asserts exactly 3*N_AGENTS+1 cycles after the edge-detect cycle (13 for N=4).
- Each slot is a fixed 3 cycles, regardless of dir_vld.
- Position outputs change only in COMMIT; all other cycles hold them stable.
- Wall geometry:
  - Walls are WALL_RECTS with inclusive bounds, identical to the background maze. Example: middle box left wall is x 461..464, y 349..419.
  - Playfield interior is x 6..1018, y 6..762; anything outside the interior counts as wall.
  - Hit = any overlap between the inclusive candidate box and any wall rectangle, or any part of the box outside the interior.
- No agent-to-agent blocking.
- rst mid-frame: returns to IDLE immediately; all outputs go to their reset values on the next edge.

Optional Feature:
MOVE_SCHED_COLLIDE_EN.
- Defined:
  - Adds output catch (1 bit).
  - In DONE, catch pulses for one cycle if agent 0's committed box overlaps any ghost box (inclusive bounds).
  - The comparison is registered; catch pulses 1 cycle after frame_done.
- Undefined: port absent, no logic added.

Decomposition:
- Package maze_pkg:
  - dir_t enum {UP, DOWN, LEFT, RIGHT}.
  - SPRITE_W=32, SPRITE_H=32.
  - PLAY_X_MIN/MAX, PLAY_Y_MIN/MAX.
  - N_WALLS; WALL_RECTS array of {x0,y0,x1,y1}.
  - START_X/START_Y arrays.
  - HOR_PIXELS=1024, VER_PIXELS=768.
- Sub-module wall_check:
  - Takes a query box and returns a registered hit bit.
  - Evaluates all WALL_RECTS in parallel.
  - Shared by all agents; owned solely by this scheduler.

Test Plan:
- Reset: rst 2 cycles -> xpos[0]=496, ypos[0]=720, xpos[1]=470, busy=0, blocked=0.
- Agent 0 RIGHT, dir_vld=0001, vblnk 0->1 -> busy=1; frame_done exactly 13 cycles later; xpos[0]=497, others unchanged.
- Agent 1 LEFT held for 6 frames -> xpos[1]=469,468,467,466,465; on frame 6, xpos[1]=465 and blocked[1]=1.
- Agent 0 DOWN held for 12 frames -> ypos[0] reaches 731 after 11 frames; on frame 12, ypos[0]=731 and blocked[0]=1.
- vblnk held high for 50 cycles, plus an extra 0->1 edge while busy -> exactly one frame_done, positions moved exactly once.
- rst at cycle 5 of a frame -> next cycle busy=0, positions at START values, no frame_done pulse.
